// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-network observation blocks.
package snn_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int MEM_W_DEF = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mon_state_e;

    // Increment v, holding at the all-ones value of a w-bit field (1 <= w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = 32'hFFFF_FFFF >> (32 - w);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/spike_rate_monitor_if.sv
// Observation bus between the LIF stage / tile pins and the spike rate monitor.
interface spike_rate_monitor_if
    import snn_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int MEM_W = MEM_W_DEF
);
    logic             en;
    logic             spike;
    logic [MEM_W-1:0] membrane;
    logic [CNT_W-1:0] window_len;
    logic [CNT_W-1:0] rate;
    logic [MEM_W-1:0] peak;
    logic             rate_valid;
    logic [CNT_W-1:0] isi;
    logic             isi_valid;
    logic             isi_ovf;

    modport master (
        output en, spike, membrane, window_len,
        input  rate, peak, rate_valid, isi, isi_valid, isi_ovf
    );

    modport slave (
        input  en, spike, membrane, window_len,
        output rate, peak, rate_valid, isi, isi_valid, isi_ovf
    );
endinterface

// File: rtl/sat_counter.sv
// Unsigned up-counter that sticks at all-ones; clr beats load1 beats inc.
module sat_counter
    import snn_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load1,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (load1) begin
            q_d = W'(1);
        end else if (inc) begin
            q_d = W'(sat_inc(32'(q_q), W));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/spike_rate_monitor.sv
// Passive observer of the LIF stage: windowed spike rate, peak membrane and
// last inter-spike interval, all published from registers.
module spike_rate_monitor
    import snn_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int MEM_W = MEM_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    spike_rate_monitor_if.slave   mon
);
    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [MEM_W-1:0] pk_acc_q, pk_acc_d;
    logic [CNT_W-1:0] rate_q, rate_d;
    logic [MEM_W-1:0] peak_q, peak_d;
    logic [CNT_W-1:0] isi_q, isi_d;
    logic             rate_valid_q, rate_valid_d;
    logic             isi_valid_q, isi_valid_d;
    logic             armed_q, armed_d;
    logic             isi_ovf_q, isi_ovf_d;

    logic [CNT_W-1:0] wpos, acc, isi_cnt;
    logic [CNT_W-1:0] len_cur, last_pos;
    logic [MEM_W-1:0] mem_max;
    logic             run, win_end;

    assign run = (state_q == ST_RUN) && mon.en;
    // Position 0 uses the live window_len so a new length applies from the first cycle.
    assign len_cur  = (wpos == '0) ? mon.window_len : len_q;
    assign last_pos = len_cur - CNT_W'(1);
    assign win_end  = run && (wpos == last_pos);
    assign mem_max  = (mon.membrane > pk_acc_q) ? mon.membrane : pk_acc_q;

    sat_counter #(.W(CNT_W)) u_wpos (
        .clk(clk), .rst(rst), .clr(!run || win_end), .load1(1'b0), .inc(run), .q(wpos)
    );

    sat_counter #(.W(CNT_W)) u_acc (
        .clk(clk), .rst(rst), .clr(!run || win_end), .load1(1'b0), .inc(run && mon.spike), .q(acc)
    );

    sat_counter #(.W(CNT_W)) u_isi_cnt (
        .clk(clk), .rst(rst), .clr(!run), .load1(run && mon.spike), .inc(run), .q(isi_cnt)
    );

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        pk_acc_d     = pk_acc_q;
        rate_d       = rate_q;
        peak_d       = peak_q;
        isi_d        = isi_q;
        rate_valid_d = 1'b0;
        isi_valid_d  = 1'b0;
        armed_d      = armed_q;
        isi_ovf_d    = isi_ovf_q;

        case (state_q)
            ST_IDLE: if (mon.en)  state_d = ST_RUN;
            ST_RUN:  if (!mon.en) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (!run) begin
            pk_acc_d  = '0;
            armed_d   = 1'b0;
            isi_ovf_d = 1'b0;
        end else begin
            if (wpos == '0) len_d = mon.window_len;
            pk_acc_d = win_end ? '0 : mem_max;
            if (win_end) begin
                rate_d       = mon.spike ? CNT_W'(sat_inc(32'(acc), CNT_W)) : acc;
                peak_d       = mem_max;
                rate_valid_d = 1'b1;
            end
            if (mon.spike) begin
                if (armed_q) begin
                    isi_d       = isi_cnt;
                    isi_valid_d = 1'b1;
                    if (isi_cnt == '1) isi_ovf_d = 1'b1;
                end
                armed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            pk_acc_q     <= '0;
            rate_q       <= '0;
            peak_q       <= '0;
            isi_q        <= '0;
            rate_valid_q <= 1'b0;
            isi_valid_q  <= 1'b0;
            armed_q      <= 1'b0;
            isi_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            pk_acc_q     <= pk_acc_d;
            rate_q       <= rate_d;
            peak_q       <= peak_d;
            isi_q        <= isi_d;
            rate_valid_q <= rate_valid_d;
            isi_valid_q  <= isi_valid_d;
            armed_q      <= armed_d;
            isi_ovf_q    <= isi_ovf_d;
        end
    end

    assign mon.rate       = rate_q;
    assign mon.peak       = peak_q;
    assign mon.rate_valid = rate_valid_q;
    assign mon.isi        = isi_q;
    assign mon.isi_valid  = isi_valid_q;
    assign mon.isi_ovf    = isi_ovf_q;
endmodule

// File: tb/tb_spike_rate_monitor.sv
// Scoreboard bench for spike_rate_monitor: a window/timestamp reference model
// queues expected publishes, a negedge monitor pops and compares them.
module tb_spike_rate_monitor;
    import snn_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spike_rate_monitor_if #(.CNT_W(8), .MEM_W(8)) bus ();
    spike_rate_monitor #(.CNT_W(8), .MEM_W(8)) dut (.clk(clk), .rst(rst), .mon(bus));

    int checks = 0;
    int errors = 0;

    typedef struct { int rate; int peak; } win_t;
    win_t win_q[$];
    int   isi_q[$];
    win_t mon_w;
    int   mon_i;

    // Reference model: window as a list of samples, ISI from run-cycle timestamps.
    bit m_run;
    int m_wpos, m_len, m_t, m_last;
    int m_spk[$];
    int m_mem[$];
    int m_ovf, exp_rate, exp_peak, exp_isi;

    int seen_rate, seen_peak, seen_isi, rv_count, iv_count, coincide;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear_run();
        m_wpos = 0;
        m_spk.delete();
        m_mem.delete();
        m_last = -1;
        m_ovf  = 0;
    endfunction

    function automatic void model_reset();
        m_run = 1'b0;
        model_clear_run();
        m_t = 0;
        m_len = 256;
        exp_rate = 0;
        exp_peak = 0;
        exp_isi = 0;
        win_q.delete();
        isi_q.delete();
    endfunction

    function automatic void model_step(input logic e, input logic s, input int m, input int wl);
        int sum, mx, d;
        if (!m_run) begin
            if (e) m_run = 1'b1;
            model_clear_run();
            return;
        end
        if (!e) begin
            m_run = 1'b0;
            model_clear_run();
            return;
        end
        if (m_wpos == 0) m_len = (wl == 0) ? 256 : wl;
        m_spk.push_back(int'(s));
        m_mem.push_back(m);
        if (s) begin
            if (m_last >= 0) begin
                d = m_t - m_last;
                exp_isi = (d > 255) ? 255 : d;
                if (d >= 255) m_ovf = 1;
                isi_q.push_back(exp_isi);
            end
            m_last = m_t;
        end
        m_t++;
        m_wpos++;
        if (m_wpos == m_len) begin
            sum = 0;
            mx = 0;
            foreach (m_spk[k]) sum += m_spk[k];
            foreach (m_mem[k]) if (m_mem[k] > mx) mx = m_mem[k];
            exp_rate = (sum > 255) ? 255 : sum;
            exp_peak = mx;
            win_q.push_back('{rate: exp_rate, peak: exp_peak});
            m_wpos = 0;
            m_spk.delete();
            m_mem.delete();
        end
    endfunction

    task automatic step(input logic e, input logic s, input int m, input int wl);
        bus.en = e;
        bus.spike = s;
        bus.membrane = 8'(m);
        bus.window_len = 8'(wl);
        @(posedge clk);
        if (rst) model_reset();
        else model_step(e, s, m, wl);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rate_valid && bus.isi_valid) coincide++;
            if (bus.rate_valid) begin
                rv_count++;
                if (win_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rate_valid rate=%0d expected no pulse at %0t", bus.rate, $time);
                end else begin
                    mon_w = win_q.pop_front();
                    check("rate", int'(bus.rate), mon_w.rate);
                    check("peak", int'(bus.peak), mon_w.peak);
                    seen_rate = bus.rate;
                    seen_peak = bus.peak;
                end
            end
            if (bus.isi_valid) begin
                iv_count++;
                if (isi_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_isi_valid isi=%0d expected no pulse at %0t", bus.isi, $time);
                end else begin
                    mon_i = isi_q.pop_front();
                    check("isi", int'(bus.isi), mon_i);
                    seen_isi = bus.isi;
                end
            end
            if (win_q.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL missing_rate_valid actual=no pulse expected rate=%0d at %0t", win_q[0].rate, $time);
                win_q.delete();
            end
            if (isi_q.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL missing_isi_valid actual=no pulse expected isi=%0d at %0t", isi_q[0], $time);
                isi_q.delete();
            end
            check("isi_ovf", int'(bus.isi_ovf), m_ovf);
            check("rate_hold", int'(bus.rate), exp_rate);
            check("peak_hold", int'(bus.peak), exp_peak);
            check("isi_hold", int'(bus.isi), exp_isi);
        end
    end

    int wl_cur, c0, rv0;
    int ramp[8] = '{0, 40, 80, 120, 160, 200, 5, 5};

    initial begin
        bus.en = 1'b0;
        bus.spike = 1'b0;
        bus.membrane = '0;
        bus.window_len = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_rate", int'(bus.rate), 0);
        check("reset_peak", int'(bus.peak), 0);
        check("reset_isi", int'(bus.isi), 0);
        check("reset_rate_valid", int'(bus.rate_valid), 0);
        check("reset_isi_valid", int'(bus.isi_valid), 0);
        check("reset_isi_ovf", int'(bus.isi_ovf), 0);
        rst = 1'b0;
        step(1'b0, 1'b0, 0, 10);

        // periodic spikes
        step(1'b1, 1'b0, 0, 10);
        for (int i = 0; i < 60; i++) begin
            if (i == 11) check("periodic_first_rate", seen_rate, 4);
            step(1'b1, (i % 3) == 0, int'($urandom_range(0, 255)), 10);
        end
        check("periodic_isi", seen_isi, 3);

        // saturation with a 256-cycle window
        step(1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 256; i++) step(1'b1, 1'b1, int'($urandom_range(0, 255)), 0);
        step(1'b1, 1'b0, 0, 0);
        check("saturated_rate", seen_rate, 255);

        // long silence
        step(1'b0, 1'b0, 0, 20);
        step(1'b0, 1'b0, 0, 20);
        check("ovf_cleared_by_idle", int'(bus.isi_ovf), 0);
        step(1'b1, 1'b0, 0, 20);
        step(1'b1, 1'b1, 7, 20);
        for (int i = 0; i < 299; i++) step(1'b1, 1'b0, 7, 20);
        step(1'b1, 1'b1, 7, 20);
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 7, 20);
        check("long_isi", seen_isi, 255);
        check("long_isi_ovf_sticky", int'(bus.isi_ovf), 1);

        // boundary spikes at wpos=len-1 and the following position 0
        step(1'b0, 1'b0, 0, 5);
        step(1'b0, 1'b0, 0, 5);
        c0 = coincide;
        step(1'b1, 1'b0, 0, 5);
        for (int i = 0; i < 15; i++) begin
            if (i == 6) check("boundary_first_rate", seen_rate, 2);
            if (i == 11) check("boundary_second_rate", seen_rate, 1);
            step(1'b1, (i == 1) || (i == 4) || (i == 5), 3, 5);
        end
        check("boundary_coincide", int'(coincide > c0), 1);

        // peak tracking
        step(1'b0, 1'b0, 0, 8);
        step(1'b0, 1'b0, 0, 8);
        step(1'b1, 1'b0, 0, 8);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, ramp[i], 8);
        step(1'b1, 1'b0, 0, 8);
        check("ramp_peak", seen_peak, 200);

        // randomized traffic with occasional length changes and enable drops
        wl_cur = 7;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) wl_cur = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 15));
            step($urandom_range(0, 49) != 0, $urandom_range(0, 3) == 0, int'($urandom_range(0, 255)), wl_cur);
        end

        // reset asserted mid-window
        step(1'b0, 1'b0, 0, 10);
        step(1'b0, 1'b0, 0, 10);
        step(1'b1, 1'b0, 0, 10);
        for (int i = 0; i < 15; i++) step(1'b1, (i % 4) == 0, 90, 10);
        check("pre_reset_rate", int'(bus.rate), 3);
        rv0 = rv_count;
        rst = 1'b1;
        model_reset();
        #1;
        check("midrst_rate", int'(bus.rate), 0);
        check("midrst_peak", int'(bus.peak), 0);
        check("midrst_isi", int'(bus.isi), 0);
        check("midrst_rate_valid", int'(bus.rate_valid), 0);
        check("midrst_isi_valid", int'(bus.isi_valid), 0);
        check("midrst_isi_ovf", int'(bus.isi_ovf), 0);
        step(1'b1, 1'b0, 0, 10);
        step(1'b1, 1'b0, 0, 10);
        rst = 1'b0;
        step(1'b0, 1'b0, 0, 10);
        check("midrst_no_publish", rv_count, rv0);

        // enable dropped mid-window
        step(1'b1, 1'b0, 0, 10);
        for (int i = 0; i < 14; i++) step(1'b1, (i % 2) == 0, 50, 10);
        rv0 = rv_count;
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 60, 10);
        check("endrop_rate_hold", int'(bus.rate), 5);
        check("endrop_no_pulse", rv_count, rv0);

        check("final_win_q_empty", win_q.size(), 0);
        check("final_isi_q_empty", isi_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
